// File: rtl/sine_rom_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sine_rom_scheduler
// Purpose  : two periodic tick channels sharing one ROM read port (round-robin)
// Revision : 1.0
// ============================================================================
module sine_rom_scheduler #(
    parameter int ROM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [15:0] period0,
    input  logic [15:0] period1,
    input  logic [5:0]  phase1,
    output logic        rom_en,
    output logic [5:0]  rom_addr,
    input  logic [31:0] rom_data,
    output logic [31:0] width0,
    output logic [31:0] width1,
    output logic        upd0,
    output logic        upd1,
    output logic [1:0]  overrun
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        CAPTURE = 2'd3
    } state_t;

    localparam logic [1:0] WAIT_LAST = (ROM_LAT > 1) ? 2'(ROM_LAT - 2) : 2'd0;

    state_t      state;
    state_t      state_nx;
    logic [15:0] cnt0;
    logic [15:0] cnt1;
    logic [15:0] prd0;
    logic [15:0] prd1;
    logic [15:0] eff0;
    logic [15:0] eff1;
    logic [1:0]  tick;
    logic [1:0]  pend;
    logic [1:0]  req;
    logic [1:0]  grant;
    logic        grant_ch;
    logic        gnt_ch;
    logic        last_ch;
    logic [1:0]  wait_cnt;
    logic [5:0]  addr0;
    logic [5:0]  addr1;

    // The interval length is taken from the live input at the first count of
    // each interval and held for the rest of it.
    assign eff0 = (cnt0 == 16'd0) ? period0 : prd0;
    assign eff1 = (cnt1 == 16'd0) ? period1 : prd1;
    assign tick[0] = en && (cnt0 == eff0);
    assign tick[1] = en && (cnt1 == eff1);

    assign rom_en   = (state == ISSUE);
    assign rom_addr = rom_en ? (gnt_ch ? addr1 : addr0) : 6'd0;

    always_comb begin
        state_nx = state;
        grant    = 2'b00;
        grant_ch = 1'b0;
        // A tick may be granted in the very cycle it arrives.
        req      = pend | tick;
        case (state)
            IDLE: begin
                if (req != 2'b00) begin
                    grant_ch = (req == 2'b11) ? ~last_ch : req[1];
                    grant    = grant_ch ? 2'b10 : 2'b01;
                    state_nx = ISSUE;
                end
            end
            ISSUE:   state_nx = (ROM_LAT == 1) ? CAPTURE : WAIT;
            WAIT:    if (wait_cnt == WAIT_LAST) state_nx = CAPTURE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (!en) begin
            state_nx = IDLE;
            grant    = 2'b00;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt0     <= 16'd0;
            cnt1     <= 16'd0;
            prd0     <= 16'd0;
            prd1     <= 16'd0;
            pend     <= 2'b00;
            overrun  <= 2'b00;
            addr0    <= 6'd0;
            addr1    <= phase1;
            width0   <= 32'd0;
            width1   <= 32'd0;
            upd0     <= 1'b0;
            upd1     <= 1'b0;
            gnt_ch   <= 1'b0;
            last_ch  <= 1'b1;
            wait_cnt <= 2'd0;
        end else begin
            state <= state_nx;
            upd0  <= 1'b0;
            upd1  <= 1'b0;
            if (!en) begin
                cnt0     <= 16'd0;
                cnt1     <= 16'd0;
                pend     <= 2'b00;
                addr0    <= 6'd0;
                addr1    <= phase1;
                wait_cnt <= 2'd0;
            end else begin
                cnt0     <= tick[0] ? 16'd0 : cnt0 + 16'd1;
                cnt1     <= tick[1] ? 16'd0 : cnt1 + 16'd1;
                prd0     <= eff0;
                prd1     <= eff1;
                pend     <= (pend | tick) & ~grant;
                overrun  <= overrun | (tick & pend & ~grant);
                wait_cnt <= (state == WAIT) ? wait_cnt + 2'd1 : 2'd0;
                if (grant != 2'b00) begin
                    gnt_ch  <= grant_ch;
                    last_ch <= grant_ch;
                end
                if (state == CAPTURE) begin
                    if (gnt_ch) begin
                        width1 <= rom_data;
                        upd1   <= 1'b1;
                        addr1  <= addr1 + 6'd1;
                    end else begin
                        width0 <= rom_data;
                        upd0   <= 1'b1;
                        addr0  <= addr0 + 6'd1;
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sine_rom_scheduler.sv
`default_nettype none
// Bench: three ROM latencies driven in parallel, checked every cycle against a
// schedule-level model plus directed literal checks.
module tb_sine_rom_scheduler;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en  = 1'b0;
    logic [15:0]      period0 = 16'd0;
    logic [15:0]      period1 = 16'd0;
    logic [5:0]       phase1  = 6'd0;
    logic [2:0]       rom_en_s;
    logic [2:0][5:0]  rom_addr_s;
    logic [2:0][31:0] rom_data_s;
    logic [2:0][31:0] width0_s;
    logic [2:0][31:0] width1_s;
    logic [2:0]       upd0_s;
    logic [2:0]       upd1_s;
    logic [2:0][1:0]  overrun_s;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < 3; i++) begin : g_dut
        sine_rom_scheduler #(.ROM_LAT(i + 1)) dut (
            .clk      (clk),
            .rst      (rst),
            .en       (en),
            .period0  (period0),
            .period1  (period1),
            .phase1   (phase1),
            .rom_en   (rom_en_s[i]),
            .rom_addr (rom_addr_s[i]),
            .rom_data (rom_data_s[i]),
            .width0   (width0_s[i]),
            .width1   (width1_s[i]),
            .upd0     (upd0_s[i]),
            .upd1     (upd1_s[i]),
            .overrun  (overrun_s[i])
        );
    end

    function automatic logic [31:0] rom_fn(input logic [5:0] a);
        return ({26'd0, a} * 32'h0104_1041) ^ 32'h5A5A_0000;
    endfunction

    // ROM: data is valid only in the cycle exactly ROM_LAT after the strobe.
    logic [6:0] pipe [3][4];
    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            for (int j = 3; j > 0; j--) pipe[k][j] = pipe[k][j-1];
            pipe[k][0] = {rom_en_s[k], rom_addr_s[k]};
            if (pipe[k][k+1][6] === 1'b1) rom_data_s[k] = rom_fn(pipe[k][k+1][5:0]);
            else                          rom_data_s[k] = $urandom;
        end
    end

    // Model: tick timing, pending flags, and a service timestamp per instance.
    bit        m_ok = 1'b0;
    int        m_el [3][2];
    int        m_iv [3][2];
    bit [1:0]  m_pend [3];
    bit [1:0]  m_ovr [3];
    bit [1:0]  m_upd [3];
    bit [5:0]  m_addr [3][2];
    bit [31:0] m_w [3][2];
    bit        m_last [3];
    bit        m_act [3];
    bit        m_ch [3];
    bit        m_romen [3];
    bit [5:0]  m_saddr [3];
    bit [5:0]  m_romaddr [3];
    int        m_g [3];

    always @(negedge clk) begin
        bit [1:0] tk;
        bit [1:0] req;
        bit [1:0] gr;
        bit       idle_now;
        int       p;
        for (int k = 0; k < 3; k++) begin
            if (m_ok) begin
                tests++;
                if ({rom_en_s[k], rom_addr_s[k], width0_s[k], width1_s[k], upd1_s[k], upd0_s[k], overrun_s[k]} !==
                    {m_romen[k], m_romaddr[k], m_w[k][0], m_w[k][1], m_upd[k], m_ovr[k]}) begin
                    fails++;
                    $display("FAIL model_cmp lat%0d cyc %0d: got en=%b addr=%0d w0=%h w1=%h upd=%b%b ovr=%b, expected en=%b addr=%0d w0=%h w1=%h upd=%b ovr=%b",
                             k + 1, cyc, rom_en_s[k], rom_addr_s[k], width0_s[k], width1_s[k], upd1_s[k], upd0_s[k], overrun_s[k],
                             m_romen[k], m_romaddr[k], m_w[k][0], m_w[k][1], m_upd[k], m_ovr[k]);
                end
            end
            if (rst) begin
                for (int n = 0; n < 2; n++) begin
                    m_el[k][n] = 0;
                    m_iv[k][n] = 0;
                    m_w[k][n]  = 32'd0;
                end
                m_addr[k][0] = 6'd0;
                m_addr[k][1] = phase1;
                m_pend[k]    = 2'b00;
                m_ovr[k]     = 2'b00;
                m_upd[k]     = 2'b00;
                m_last[k]    = 1'b1;
                m_act[k]     = 1'b0;
                m_romen[k]   = 1'b0;
                m_romaddr[k] = 6'd0;
            end else if (!en) begin
                m_el[k][0]   = 0;
                m_el[k][1]   = 0;
                m_addr[k][0] = 6'd0;
                m_addr[k][1] = phase1;
                m_pend[k]    = 2'b00;
                m_upd[k]     = 2'b00;
                m_act[k]     = 1'b0;
                m_romen[k]   = 1'b0;
                m_romaddr[k] = 6'd0;
            end else begin
                for (int n = 0; n < 2; n++) begin
                    p = (n == 0) ? int'(period0) : int'(period1);
                    if (m_el[k][n] == 0) m_iv[k][n] = p;
                    tk[n] = (m_el[k][n] == m_iv[k][n]);
                    m_el[k][n] = tk[n] ? 0 : m_el[k][n] + 1;
                end
                m_upd[k]     = 2'b00;
                m_romen[k]   = 1'b0;
                m_romaddr[k] = 6'd0;
                gr           = 2'b00;
                idle_now     = !m_act[k];
                // Capture lands ROM_LAT (= k+1) cycles after the strobe, which is one after the grant.
                if (m_act[k] && cyc == m_g[k] + k + 2) begin
                    m_w[k][m_ch[k]]    = rom_fn(m_saddr[k]);
                    m_upd[k][m_ch[k]]  = 1'b1;
                    m_addr[k][m_ch[k]] = m_saddr[k] + 6'd1;
                    m_act[k]           = 1'b0;
                end
                if (idle_now) begin
                    req = m_pend[k] | tk;
                    if (req != 2'b00) begin
                        m_ch[k]      = (req == 2'b11) ? !m_last[k] : req[1];
                        m_last[k]    = m_ch[k];
                        m_act[k]     = 1'b1;
                        m_g[k]       = cyc;
                        m_saddr[k]   = m_addr[k][m_ch[k]];
                        m_romen[k]   = 1'b1;
                        m_romaddr[k] = m_saddr[k];
                        gr[m_ch[k]]  = 1'b1;
                    end
                end
                for (int n = 0; n < 2; n++) begin
                    if (tk[n] && m_pend[k][n] && !gr[n]) m_ovr[k][n] = 1'b1;
                    m_pend[k][n] = gr[n] ? 1'b0 : (m_pend[k][n] | tk[n]);
                end
            end
        end
        if (rst) m_ok = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rom(input int k, input int maxc, output int t, output logic [5:0] a);
        t = -1;
        a = 6'd0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (rom_en_s[k] === 1'b1) begin
                t = cyc;
                a = rom_addr_s[k];
                break;
            end
        end
        if (t < 0) begin
            tests++;
            fails++;
            $display("FAIL rom_timeout lat%0d: no rom_en within %0d cycles", k + 1, maxc);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         e0, t, t2, tp, n;
        logic [5:0] a, a2;

        // Reset values, then ch0 alone with a 10-cycle interval.
        period0 = 16'd9; period1 = 16'hFFFF; phase1 = 6'd16;
        do_reset();
        @(negedge clk);
        chk("reset_rom_en",   rom_en_s[0],   0);
        chk("reset_rom_addr", rom_addr_s[0], 0);
        chk("reset_width0",   width0_s[0],   0);
        chk("reset_upd",      {upd1_s[0], upd0_s[0]}, 0);
        chk("reset_overrun",  overrun_s[0],  0);
        step();
        en = 1'b1; e0 = cyc;
        wait_rom(0, 20, t, a);
        chk("first_tick_delay", t - e0, 10);
        chk("first_addr", a, 0);
        @(negedge clk);
        @(negedge clk);
        chk("upd0_latency", upd0_s[0], 1);
        chk("width0_first", width0_s[0], rom_fn(6'd0));
        for (int i = 1; i <= 64; i++) begin
            tp = t;
            wait_rom(0, 15, t, a);
            chk("tick_interval", t - tp, 10);
            chk("addr_seq", a, i % 64);
        end

        // Simultaneous ticks: ch0 first, ch1 three cycles later, then alternation.
        period0 = 16'd99; period1 = 16'd99; phase1 = 6'd16;
        do_reset();
        en = 1'b1; e0 = cyc;
        wait_rom(0, 110, t, a);
        chk("dual_first_time", t - e0, 100);
        chk("dual_first_addr", a, 0);
        wait_rom(0, 10, t2, a);
        chk("dual_gap", t2 - t, 3);
        chk("dual_ch1_addr", a, 16);
        wait_rom(0, 110, t, a);
        chk("dual_second_time", t - e0, 200);
        chk("dual_second_ch0_addr", a, 1);
        wait_rom(0, 10, t2, a);
        chk("dual_second_ch1_addr", a, 17);

        // Period 0: overrun quickly, one update per three cycles.
        period0 = 16'd0; period1 = 16'hFFFF;
        do_reset();
        en = 1'b1;
        repeat (4) @(negedge clk);
        chk("overrun_fast", overrun_s[0][0], 1);
        n = 0;
        repeat (30) begin
            @(negedge clk);
            n += int'(upd0_s[0]);
        end
        chk("update_rate", n, 10);

        // Reset in mid-run clears everything, including the sticky overrun.
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("overrun_sticky", overrun_s[0][0], 1);
        @(negedge clk);
        chk("midrst_overrun", overrun_s[0], 0);
        chk("midrst_width0",  width0_s[0],  0);
        chk("midrst_rom_en",  rom_en_s[0],  0);
        chk("midrst_upd0",    upd0_s[0],    0);
        step();
        rst = 1'b0; en = 1'b0;

        // Period change mid-interval.
        period0 = 16'd9; period1 = 16'hFFFF;
        do_reset();
        en = 1'b1; e0 = cyc;
        repeat (3) step();
        period0 = 16'd4;
        wait_rom(0, 15, t, a);
        chk("period_chg_first", t - e0, 10);
        wait_rom(0, 10, t2, a);
        chk("period_chg_second", t2 - t, 5);
        tp = t2;
        wait_rom(0, 10, t2, a);
        chk("period_chg_third", t2 - tp, 5);

        // Abort during WAIT on the ROM_LAT=3 instance.
        period0 = 16'd9; period1 = 16'd9; phase1 = 6'd16;
        do_reset();
        en = 1'b1;
        repeat (21) step();
        en = 1'b0;
        n = 0;
        repeat (8) begin
            @(negedge clk);
            n += int'(upd0_s[2]) + int'(upd1_s[2]);
        end
        chk("abort_no_upd", n, 0);
        chk("abort_width0", width0_s[2], rom_fn(6'd0));
        chk("abort_width1", width1_s[2], rom_fn(6'd16));
        step();
        en = 1'b1; e0 = cyc;
        wait_rom(2, 15, t, a);
        chk("reenable_delay", t - e0, 10);
        wait_rom(2, 10, t2, a2);
        chk("reenable_gap", t2 - t, 5);
        chk("reload_addrs", ((a == 6'd0 && a2 == 6'd16) || (a == 6'd16 && a2 == 6'd0)), 1);

        // Randomized episodes, checked by the per-cycle model.
        for (int ep = 0; ep < 4; ep++) begin
            phase1  = 6'($urandom);
            period0 = 16'($urandom_range(0, 12));
            period1 = 16'($urandom_range(0, 12));
            do_reset();
            en = 1'b1;
            for (int c = 0; c < 800; c++) begin
                step();
                rst = ($urandom_range(0, 399) == 0);
                if ($urandom_range(0, 59) == 0) en = !en;
                if ($urandom_range(0, 39) == 0) period0 = 16'($urandom_range(0, 12));
                if ($urandom_range(0, 39) == 0) period1 = 16'($urandom_range(0, 12));
                if ($urandom_range(0, 99) == 0) phase1 = 6'($urandom);
            end
        end
        rst = 1'b0;
        step();
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
